// File: rtl/register_bank_if.sv
// Control <-> register bank bus: request flags, selects, write data, operands and done pulses.
// Control drives requests (master); the bank returns operands, done pulses and Busy (slave).
interface register_bank_if;
    logic [8:0]  RegSelect;
    logic        ReadFlag;
    logic        WriteFlag;
    logic [15:0] WriteData;
    logic [15:0] OperandA;
    logic [15:0] OperandB;
    logic [1:0]  DoneRegFlag;
    logic        Busy;

    modport master (
        output RegSelect, ReadFlag, WriteFlag, WriteData,
        input  OperandA, OperandB, DoneRegFlag, Busy
    );

    modport slave (
        input  RegSelect, ReadFlag, WriteFlag, WriteData,
        output OperandA, OperandB, DoneRegFlag, Busy
    );
endinterface

// File: rtl/register_bank.sv
// Eight 16-bit registers behind an IDLE/READ/WRITE FSM; REG_ZERO_HARDWIRED_EN pins R0 to zero.
// Latency: done pulse one edge after accept (write+read: two). Requests outside IDLE are dropped.
module register_bank (
    input  logic           clk,
    input  logic           reset,
    register_bank_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_regs [8];
    logic [2:0]  r_dst;
    logic [2:0]  r_src_a;
    logic [2:0]  r_src_b;
    logic [15:0] r_wdata;
    logic        r_rd_pend;
    logic [15:0] r_op_a;
    logic [15:0] r_op_b;
    logic [1:0]  r_done;

    logic        w_accept_rd;
    logic        w_accept_wr;
    logic        w_reg_we;
    logic [1:0]  w_done_nxt;
    logic        w_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A write always wins in IDLE; a simultaneous read is replayed after it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.WriteFlag) begin
                    w_state_nxt = WRITE;
                end else if (bus.ReadFlag) begin
                    w_state_nxt = READ;
                end
            end
            READ:    w_state_nxt = IDLE;
            WRITE:   w_state_nxt = r_rd_pend ? READ : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_accept_wr = (r_state == IDLE) && bus.WriteFlag;
        w_accept_rd = (r_state == IDLE) && bus.ReadFlag;
`ifdef REG_ZERO_HARDWIRED_EN
        w_reg_we    = (r_state == WRITE) && (r_dst != 3'd0);
`else
        w_reg_we    = (r_state == WRITE);
`endif
        w_done_nxt  = {r_state == WRITE, r_state == READ};
        w_busy      = (r_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dst     <= 3'd0;
            r_src_a   <= 3'd0;
            r_src_b   <= 3'd0;
            r_wdata   <= 16'h0000;
            r_rd_pend <= 1'b0;
            r_op_a    <= 16'h0000;
            r_op_b    <= 16'h0000;
            r_done    <= 2'b00;
        end else begin
            r_done    <= w_done_nxt;
            r_rd_pend <= w_accept_wr && w_accept_rd;
            if (w_accept_wr) begin
                r_dst   <= bus.RegSelect[8:6];
                r_wdata <= bus.WriteData;
            end
            if (w_accept_rd) begin
                r_src_a <= bus.RegSelect[5:3];
                r_src_b <= bus.RegSelect[2:0];
            end
            if (r_state == READ) begin
                r_op_a <= r_regs[r_src_a];
                r_op_b <= r_regs[r_src_b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else if (w_reg_we) begin
            r_regs[r_dst] <= r_wdata;
        end
    end

    assign bus.OperandA    = r_op_a;
    assign bus.OperandB    = r_op_b;
    assign bus.DoneRegFlag = r_done;
    assign bus.Busy        = w_busy;
endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: scoreboard of expected done pulses and operands.
// Build with REG_ZERO_HARDWIRED_EN defined to exercise the hardwired-R0 variant.
module tb_register_bank;
    localparam logic [1:0] K_RD = 2'b01;
    localparam logic [1:0] K_WR = 2'b10;
`ifdef REG_ZERO_HARDWIRED_EN
    localparam bit HW0 = 1'b1;
`else
    localparam bit HW0 = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    register_bank_if bus ();
    register_bank dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    exp_t        sb[$];
    logic [15:0] m_regs [8];
    int          n_asrt = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asrt++;
        assert (obs === exp_v) else begin
            n_fail++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
            $error("check %s differs", tag);
        end
    endtask

    // Drive one request across its accepting edge, then scramble inputs.
    task automatic request(input logic rd, input logic wr, input logic [2:0] d,
                           input logic [2:0] a, input logic [2:0] b, input logic [15:0] data);
        exp_t e;
        @(negedge clk);
        bus.ReadFlag  = rd;
        bus.WriteFlag = wr;
        bus.RegSelect = {d, a, b};
        bus.WriteData = data;
        if (wr) begin
            e.kind = K_WR; e.a = 16'h0; e.b = 16'h0;
            sb.push_back(e);
            if (!(HW0 && d == 3'd0)) m_regs[d] = data;
        end
        if (rd) begin
            e.kind = K_RD; e.a = m_regs[a]; e.b = m_regs[b];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.ReadFlag  = 1'b0;
        bus.WriteFlag = 1'b0;
        bus.RegSelect = 9'($urandom);
        bus.WriteData = 16'($urandom);
    endtask

    task automatic collect(input string tag, input int exp_lat);
        exp_t e;
        int   lat;
        bit   seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 8) begin
            @(negedge clk);
            lat++;
            if (bus.DoneRegFlag !== 2'b00) seen = 1'b1;
        end
        chk({tag, " done seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
            if (sb.size() == 0) begin
                chk({tag, " unexpected done"}, 32'(bus.DoneRegFlag), 32'd0);
            end else begin
                e = sb.pop_front();
                chk({tag, " done"}, 32'(bus.DoneRegFlag), 32'(e.kind));
                if (e.kind == K_RD) begin
                    chk({tag, " opa"}, 32'(bus.OperandA), 32'(e.a));
                    chk({tag, " opb"}, 32'(bus.OperandB), 32'(e.b));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        reset         = 1'b1;
        bus.ReadFlag  = 1'b1;
        bus.WriteFlag = 1'b1;
        bus.RegSelect = 9'b010_010_001;
        bus.WriteData = 16'hDEAD;
        repeat (3) @(negedge clk);
        chk("reset done", 32'(bus.DoneRegFlag), 32'd0);
        chk("reset busy", 32'(bus.Busy), 32'd0);
        chk("reset opa", 32'(bus.OperandA), 32'd0);
        chk("reset opb", 32'(bus.OperandB), 32'd0);
        reset         = 1'b0;
        bus.ReadFlag  = 1'b0;
        bus.WriteFlag = 1'b0;
        @(negedge clk);
        chk("post reset busy", 32'(bus.Busy), 32'd0);

        // Read R3/R5 straight after reset.
        request(1'b1, 1'b0, 3'd0, 3'd3, 3'd5, 16'h0);
        @(negedge clk);
        chk("rd busy", 32'(bus.Busy), 32'd1);
        chk("rd early done", 32'(bus.DoneRegFlag), 32'd0);
        collect("rd r3r5", 1);
        @(negedge clk);
        chk("rd pulse width", 32'(bus.DoneRegFlag), 32'd0);
        chk("rd idle busy", 32'(bus.Busy), 32'd0);

        // Write then read back with A == B.
        request(1'b0, 1'b1, 3'd4, 3'd0, 3'd0, 16'hBEEF);
        collect("wr r4", 2);
        @(negedge clk);
        chk("wr pulse width", 32'(bus.DoneRegFlag), 32'd0);
        request(1'b1, 1'b0, 3'd0, 3'd4, 3'd4, 16'h0);
        collect("rd r4r4", 2);

        // Simultaneous write R2 and read R2/R1.
        request(1'b1, 1'b1, 3'd2, 3'd2, 3'd1, 16'h1234);
        @(negedge clk);
        chk("combo busy k", 32'(bus.Busy), 32'd1);
        collect("combo wr", 1);
        chk("combo busy k1", 32'(bus.Busy), 32'd1);
        collect("combo rd", 1);
        @(negedge clk);
        chk("combo idle", 32'(bus.Busy), 32'd0);
        chk("combo quiet", 32'(bus.DoneRegFlag), 32'd0);

        repeat (3) @(negedge clk);
        chk("hold opa", 32'(bus.OperandA), 32'(m_regs[2]));
        chk("hold opb", 32'(bus.OperandB), 32'(m_regs[1]));

        // Second write while in WRITE must be dropped.
        request(1'b0, 1'b1, 3'd6, 3'd0, 3'd0, 16'h5555);
        @(negedge clk);
        chk("wr2 busy", 32'(bus.Busy), 32'd1);
        bus.WriteFlag = 1'b1;
        bus.RegSelect = {3'd6, 3'd0, 3'd0};
        bus.WriteData = 16'hAAAA;
        @(posedge clk);
        #1;
        bus.WriteFlag = 1'b0;
        collect("wr r6", 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wr2 no extra done", 32'(bus.DoneRegFlag), 32'd0);
        end
        request(1'b1, 1'b0, 3'd0, 3'd6, 3'd4, 16'h0);
        collect("rd r6r4", 2);

        // R0 write/read: hardwired variant reads zero.
        request(1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 16'h00FF);
        collect("wr r0", 2);
        request(1'b1, 1'b0, 3'd0, 3'd0, 3'd2, 16'h0);
        collect("rd r0r2", 2);

        // Reset while in WRITE: no commit, no pulse, everything cleared.
        request(1'b0, 1'b1, 3'd5, 3'd0, 3'd0, 16'h7777);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst wr done", 32'(bus.DoneRegFlag), 32'd0);
        chk("rst wr busy", 32'(bus.Busy), 32'd0);
        chk("rst wr opa", 32'(bus.OperandA), 32'd0);
        reset = 1'b0;
        sb.delete();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        @(negedge clk);
        chk("rst wr quiet", 32'(bus.DoneRegFlag), 32'd0);
        for (int i = 0; i < 4; i++) begin
            request(1'b1, 1'b0, 3'd0, 3'(2 * i), 3'(2 * i + 1), 16'h0);
            collect("post rst rd", 2);
        end

        chk("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
